// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule expander: accepts one padded 512-bit block and
// streams W[0..ROUNDS-1] one word per handshake beat, using a 16-word sliding window.
module sha256_msg_schedule #(
  parameter int unsigned ROUNDS = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         blk_valid,
  input  logic [511:0] blk_data,
  output logic         blk_ready,
  output logic         w_valid,
  input  logic         w_ready,
  output logic [31:0]  w_data,
  output logic [5:0]   w_idx,
  output logic         w_last,
  output logic         busy
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned IDX_W  = 6;
  localparam int unsigned WIN_N  = 16;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUNDS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [WORD_W-1:0]   win_q [WIN_N];
  logic [WORD_W-1:0]   win_d [WIN_N];
  logic [IDX_W-1:0]    t_q, t_d;
  logic                last_q, last_d;

  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x,
                                             input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic logic [WORD_W-1:0] sig0(input logic [WORD_W-1:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [WORD_W-1:0] sig1(input logic [WORD_W-1:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Ready only while idle and not in reset; depends on registered state alone.
  assign blk_ready = (state_q == IDLE) && rst_n;

  // Outputs come straight from the state, window head, index and last flops.
  assign w_valid = (state_q == EMIT);
  assign busy    = (state_q == EMIT);
  assign w_data  = win_q[0];
  assign w_idx   = t_q;
  assign w_last  = last_q;

  // Next-state, window load/shift and index bookkeeping.
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    last_d  = last_q;
    win_d   = win_q;
    case (state_q)
      IDLE: begin
        if (blk_valid && blk_ready) begin
          state_d = EMIT;
          t_d     = '0;
          last_d  = (LAST_IDX == '0);
          for (int i = 0; i < int'(WIN_N); i++) begin
            win_d[i] = blk_data[(int'(WIN_N) - 1 - i) * int'(WORD_W) +: WORD_W];
          end
        end
      end
      EMIT: begin
        if (w_ready) begin
          for (int i = 0; i < int'(WIN_N) - 1; i++) begin
            win_d[i] = win_q[i+1];
          end
          win_d[WIN_N-1] = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];
          if (last_q) begin
            state_d = IDLE;
            t_d     = '0;
            last_d  = 1'b0;
          end else begin
            t_d    = t_q + IDX_W'(1);
            last_d = (t_d == LAST_IDX);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset clears everything including the window.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      t_q     <= '0;
      last_q  <= 1'b0;
      for (int i = 0; i < int'(WIN_N); i++) begin
        win_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      last_q  <= last_d;
      win_q   <= win_d;
    end
  end

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Self-checking bench for sha256_msg_schedule: reference schedule feeds a
// scoreboard queue, words are popped and compared on every handshake beat.
module tb_sha256_msg_schedule;

  localparam int unsigned ROUNDS = 64;
  localparam logic [511:0] ABC  = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] ZERO = '0;

  typedef struct packed {
    logic [31:0] d;
    logic [5:0]  i;
    logic        l;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         blk_valid;
  logic [511:0] blk_data;
  logic         blk_ready;
  logic         w_valid;
  logic         w_ready;
  logic [31:0]  w_data;
  logic [5:0]   w_idx;
  logic         w_last;
  logic         busy;

  exp_t exp_q[$];
  int   compared;
  int   mismatched;

  sha256_msg_schedule #(.ROUNDS(ROUNDS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .blk_valid (blk_valid),
    .blk_data  (blk_data),
    .blk_ready (blk_ready),
    .w_valid   (w_valid),
    .w_ready   (w_ready),
    .w_data    (w_data),
    .w_idx     (w_idx),
    .w_last    (w_last),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Reference schedule using the textbook W[t-2]/W[t-7]/W[t-15]/W[t-16] recurrence.
  function automatic void push_block(input logic [511:0] blk);
    logic [31:0] w [64];
    exp_t e;
    for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++)
      w[t] = (ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
           + (ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
    for (int t = 0; t < int'(ROUNDS); t++) begin
      e.d = w[t];
      e.i = 6'(t);
      e.l = (t == int'(ROUNDS) - 1);
      exp_q.push_back(e);
    end
  endfunction

  // Drives w_ready, handles block-accept handshakes and pops/compares the scoreboard.
  task automatic run_words(input int mode, input int budget, input int stop_idx,
                           input bit swap_en, input logic [511:0] next_data,
                           output int first_beat, output int last_beat);
    bit          acc_pending;
    bit          swap;
    bit          held;
    logic [31:0] hd;
    logic [5:0]  hi;
    logic        hl;
    int          n;
    exp_t        e;
    acc_pending = blk_valid && blk_ready;
    swap        = swap_en;
    held        = 1'b0;
    hd = '0; hi = '0; hl = 1'b0;
    n = 0;
    first_beat = -1;
    last_beat  = -1;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      n++;
      if (n > budget) begin
        compared++; mismatched++;
        $display("FAIL timeout: %0d words still expected after %0d cycles", exp_q.size(), budget);
        exp_q.delete();
        break;
      end
      if (acc_pending) begin
        acc_pending = 1'b0;
        if (swap) begin
          swap = 1'b0;
          blk_data = next_data;
        end else begin
          blk_valid = 1'b0;
        end
      end
      if (blk_valid && blk_ready) acc_pending = 1'b1;
      if (stop_idx >= 0 && w_valid && int'(w_idx) == stop_idx) return;
      if (held) begin
        compared++;
        if (w_valid !== 1'b1 || w_data !== hd || w_idx !== hi || w_last !== hl) begin
          mismatched++;
          $display("FAIL hold_stable: got v=%b d=%h i=%0d l=%b want v=1 d=%h i=%0d l=%b",
                   w_valid, w_data, w_idx, w_last, hd, hi, hl);
        end
      end
      w_ready = (mode == 0) ? 1'b1 : ((n % 4 == 0) || (n % 4 == 3));
      compared++;
      if (busy !== w_valid) begin
        mismatched++;
        $display("FAIL busy_track: got busy=%b want %b", busy, w_valid);
      end
      if (w_valid) begin
        compared++;
        if (blk_ready !== 1'b0) begin
          mismatched++;
          $display("FAIL ready_while_busy: got %b want 0", blk_ready);
        end
      end
      if (w_valid && w_ready) begin
        e = exp_q.pop_front();
        compared++;
        if (w_data !== e.d || w_idx !== e.i || w_last !== e.l) begin
          mismatched++;
          $display("FAIL word: got d=%h i=%0d l=%b want d=%h i=%0d l=%b",
                   w_data, w_idx, w_last, e.d, e.i, e.l);
        end
        if (first_beat < 0) first_beat = n;
        last_beat = n;
      end
      held = w_valid && !w_ready;
      hd = w_data; hi = w_idx; hl = w_last;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; blk_valid = 1'b0; blk_data = '0; w_ready = 1'b0;
    repeat (3) @(negedge clk);
    compared++;
    if (w_valid !== 1'b0 || w_data !== 32'h0 || w_idx !== 6'd0 || w_last !== 1'b0 ||
        busy !== 1'b0 || blk_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_state: got v=%b d=%h i=%0d l=%b busy=%b rdy=%b want all 0",
               w_valid, w_data, w_idx, w_last, busy, blk_ready);
    end
    rst_n = 1'b1;
    #1;
    compared++;
    if (blk_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_release_ready: got %b want 1", blk_ready);
    end
  endtask

  task automatic check_idle_after(input string name);
    @(negedge clk);
    compared++;
    if (w_valid !== 1'b0 || blk_ready !== 1'b1 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL %s_idle: got v=%b rdy=%b busy=%b want v=0 rdy=1 busy=0",
               name, w_valid, blk_ready, busy);
    end
  endtask

  task automatic push_abc_literal;
    exp_t e;
    push_block(ABC);
    e = exp_q[16]; e.d = 32'h61626380; exp_q[16] = e;
    e = exp_q[17]; e.d = 32'h000F0000; exp_q[17] = e;
    e = exp_q[18]; e.d = 32'h7DA86405; exp_q[18] = e;
    e = exp_q[19]; e.d = 32'h600003C6; exp_q[19] = e;
  endtask

  task automatic test_abc;
    int f, l;
    @(negedge clk);
    push_abc_literal();
    blk_data = ABC; blk_valid = 1'b1; w_ready = 1'b1;
    run_words(0, 300, -1, 1'b0, '0, f, l);
    compared++;
    if (l - f !== 63) begin
      mismatched++;
      $display("FAIL abc_consecutive: got span %0d want 63", l - f);
    end
    check_idle_after("abc");
  endtask

  task automatic test_zero;
    int f, l;
    push_block(ZERO);
    blk_data = ZERO; blk_valid = 1'b1; w_ready = 1'b1;
    run_words(0, 300, -1, 1'b0, '0, f, l);
    compared++;
    if (l - f !== 63) begin
      mismatched++;
      $display("FAIL zero_consecutive: got span %0d want 63", l - f);
    end
    check_idle_after("zero");
  endtask

  task automatic test_backpressure;
    int f, l;
    push_abc_literal();
    blk_data = ABC; blk_valid = 1'b1;
    run_words(1, 600, -1, 1'b0, '0, f, l);
    check_idle_after("bp");
  endtask

  task automatic test_back_to_back;
    int f, l;
    logic [511:0] second;
    second = {32'hDEADBEEF, 32'h01234567, 384'h0, 32'h89ABCDEF, 32'h00000200, 32'h80000000};
    push_block(ABC);
    push_block(second);
    blk_data = ABC; blk_valid = 1'b1; w_ready = 1'b1;
    run_words(0, 600, -1, 1'b1, second, f, l);
    compared++;
    if (l - f !== 128) begin
      mismatched++;
      $display("FAIL b2b_gap: got span %0d want 128", l - f);
    end
    check_idle_after("b2b");
  endtask

  task automatic test_reset_mid_block;
    int f, l;
    push_block(ABC);
    blk_data = ABC; blk_valid = 1'b1; w_ready = 1'b1;
    run_words(0, 300, 20, 1'b0, '0, f, l);
    compared++;
    if (w_idx !== 6'd20 || w_valid !== 1'b1) begin
      mismatched++;
      $display("FAIL mid_stop: got v=%b i=%0d want v=1 i=20", w_valid, w_idx);
    end
    exp_q.delete();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    compared++;
    if (w_valid !== 1'b0 || w_idx !== 6'd0 || busy !== 1'b0 || blk_ready !== 1'b1 ||
        w_last !== 1'b0 || w_data !== 32'h0) begin
      mismatched++;
      $display("FAIL mid_reset: got v=%b i=%0d busy=%b rdy=%b l=%b d=%h want v=0 i=0 busy=0 rdy=1 l=0 d=0",
               w_valid, w_idx, busy, blk_ready, w_last, w_data);
    end
    push_abc_literal();
    blk_data = ABC; blk_valid = 1'b1;
    run_words(0, 300, -1, 1'b0, '0, f, l);
    compared++;
    if (l - f !== 63) begin
      mismatched++;
      $display("FAIL mid_replay_span: got %0d want 63", l - f);
    end
    check_idle_after("mid");
  endtask

  task automatic test_reset_on_accept;
    blk_data = ABC; blk_valid = 1'b1; rst_n = 1'b0;
    #1;
    compared++;
    if (blk_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL accept_reset_ready: got %b want 0", blk_ready);
    end
    @(negedge clk);
    rst_n = 1'b1; blk_valid = 1'b0;
    #1;
    compared++;
    if (w_valid !== 1'b0 || busy !== 1'b0 || blk_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL accept_reset_idle: got v=%b busy=%b rdy=%b want v=0 busy=0 rdy=1",
               w_valid, busy, blk_ready);
    end
    repeat (2) begin
      @(negedge clk);
      compared++;
      if (w_valid !== 1'b0) begin
        mismatched++;
        $display("FAIL accept_reset_novalid: got %b want 0", w_valid);
      end
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    test_reset();
    test_abc();
    test_zero();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_block();
    test_reset_on_accept();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
